// File: rtl/fire_layer_sequencer.sv
// fire_layer_sequencer: runs fire-module layers one at a time with an ack pulse and idle gap between them
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   start         level, sampled only while idle
//   layer_finish  per-layer finish levels
//   layer_en      one-hot (or zero) layer enables
//   ram_feedback  one-cycle acknowledge to the finished layer
//   cur_layer     index of the active or most recent layer
//   busy          high whenever not idle
//   done          one-cycle pulse after the last layer is acknowledged
//   error         sticky watchdog flag
// Optional macro FIRE_SEQ_WATCHDOG_EN adds a per-layer RUN timeout; without it error stays 0.
module fire_layer_sequencer #(
    parameter int NUM_LAYERS = 8,
    parameter int GAP        = 2,
    parameter int TIMEOUT    = 1048576,
    localparam int CW        = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_LAYERS-1:0] layer_finish,
    output logic [NUM_LAYERS-1:0] layer_en,
    output logic [NUM_LAYERS-1:0] ram_feedback,
    output logic [CW-1:0]         cur_layer,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_ACK, S_GAP, S_FIN} state_t;
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] LAST     = CW'(NUM_LAYERS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    state_t                  state_q, state_d;
    logic [CW-1:0]           cur_q, cur_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic                    error_q, error_d;
    logic [NUM_LAYERS-1:0]   en_q, en_d, rf_q, rf_d;
    logic                    busy_q, busy_d, done_q, done_d;
`ifdef FIRE_SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    logic [WDW-1:0] wd_q, wd_d;
`endif
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        gap_d   = gap_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RUN;
                cur_d   = '0;
                error_d = 1'b0;
            end
            S_RUN: begin
                // finish takes priority over a simultaneous timeout
                if (layer_finish[cur_q]) state_d = S_ACK;
`ifdef FIRE_SEQ_WATCHDOG_EN
                else if (wd_q == WD_LAST) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end
`endif
            end
            S_ACK: begin
                gap_d = '0;
                if (cur_q == LAST) state_d = S_FIN;
                else if (GAP == 0) begin
                    state_d = S_RUN;
                    cur_d   = cur_q + CW'(1);
                end else state_d = S_GAP;
            end
            S_GAP: if (gap_q == GAP_LAST) begin
                state_d = S_RUN;
                cur_d   = cur_q + CW'(1);
            end else gap_d = gap_q + GW'(1);
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // outputs are decoded from the next state so they register alongside it
        en_d   = (state_d == S_RUN) ? NUM_LAYERS'(1) << cur_d : '0;
        rf_d   = (state_d == S_ACK) ? NUM_LAYERS'(1) << cur_d : '0;
        busy_d = state_d != S_IDLE;
        done_d = state_d == S_FIN;
    end
`ifdef FIRE_SEQ_WATCHDOG_EN
    // counts cycles spent in the current RUN; zero on every entry
    assign wd_d = (state_q == S_RUN && state_d == S_RUN) ? wd_q + WDW'(1) : '0;
    always_ff @(posedge clk or negedge rst)
        if (!rst) wd_q <= '0;
        else      wd_q <= wd_d;
`endif
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            gap_q   <= '0;
            error_q <= 1'b0;
            en_q    <= '0;
            rf_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            gap_q   <= gap_d;
            error_q <= error_d;
            en_q    <= en_d;
            rf_q    <= rf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    assign layer_en     = en_q;
    assign ram_feedback = rf_q;
    assign cur_layer    = cur_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
endmodule
